// File: rtl/uart_pkt_arbiter_pkg.sv
// Shared definitions for the UART packet arbiter: FSM encoding and default timing constants.
package uart_pkt_arbiter_pkg;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_LOAD       = 3'd1;
   localparam logic [2:0] ST_PULSE      = 3'd2;
   localparam logic [2:0] ST_WAIT_START = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE  = 3'd4;
   localparam logic [2:0] ST_GAP        = 3'd5;

   typedef enum logic [2:0] {
      IDLE       = ST_IDLE,
      LOAD       = ST_LOAD,
      PULSE      = ST_PULSE,
      WAIT_START = ST_WAIT_START,
      WAIT_DONE  = ST_WAIT_DONE,
      GAP        = ST_GAP
   } arb_state_e;

   localparam logic [15:0] BYTE_GAP_DEF      = 16'd255;
   localparam logic [15:0] START_TIMEOUT_DEF = 16'd64;

endpackage

// File: rtl/uart_pkt_arbiter_rr_pick.sv
// Round-robin picker: first valid requester strictly after last_grant, wrapping modulo NUM_REQ.
module uart_pkt_arbiter_rr_pick
   import uart_pkt_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int GNT_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [GNT_W-1:0]   last_grant,
   output logic [GNT_W-1:0]   gnt,
   output logic               any_valid
);

   logic [GNT_W-1:0] idx;

   always_comb begin
      gnt       = '0;
      any_valid = 1'b0;
      idx       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = GNT_W'((32'(last_grant) + 32'(k)) % NUM_REQ);
         if (!any_valid && req_valid[idx]) begin
            any_valid = 1'b1;
            gnt       = idx;
         end
      end
   end

endmodule

// File: rtl/uart_pkt_arbiter.sv
// Shares one uart_tx between NUM_REQ packet sources: whole packets granted round-robin,
// each byte pulsed into the transmitter, re-pulsed on start timeout, then an inter-byte gap.
module uart_pkt_arbiter
   import uart_pkt_arbiter_pkg::*;
#(
   parameter int          NUM_REQ       = 2,
   parameter int          GNT_W         = 1,
   parameter logic [15:0] BYTE_GAP      = BYTE_GAP_DEF,
   parameter logic [15:0] START_TIMEOUT = START_TIMEOUT_DEF
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_pluse,
   input  logic                 tx_busy,
   output logic [GNT_W-1:0]     grant_id,
   output logic                 arb_busy,
   output logic                 pkt_done,
   output logic                 timeout_err
);

   arb_state_e       state_q, state_d;
   logic [GNT_W-1:0] grant_id_q, grant_id_d;
   logic [GNT_W-1:0] last_grant_q, last_grant_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_pluse_q, tx_pluse_d;
   logic             arb_busy_q, arb_busy_d;
   logic             pkt_done_q, pkt_done_d;
   logic             timeout_err_q, timeout_err_d;
   logic             last_byte_q, last_byte_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             busy_d0_q, busy_d0_d;
   logic             busy_d1_q, busy_d1_d;

   logic [GNT_W-1:0] pick_gnt;
   logic             pick_any;
   logic [7:0]       req_byte [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_byte
      assign req_byte[i] = req_data[8*i +: 8];
   end

   uart_pkt_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .GNT_W   (GNT_W)
   ) u_rr_pick (
      .req_valid  (req_valid),
      .last_grant (last_grant_q),
      .gnt        (pick_gnt),
      .any_valid  (pick_any)
   );

   // Ready is combinational so the byte is taken in the same cycle the owner offers it.
   always_comb begin
      req_ready = '0;
      if (state_q == LOAD && req_valid[grant_id_q]) req_ready[grant_id_q] = 1'b1;
   end

   always_comb begin
      state_d       = state_q;
      grant_id_d    = grant_id_q;
      last_grant_d  = last_grant_q;
      tx_data_d     = tx_data_q;
      arb_busy_d    = arb_busy_q;
      pkt_done_d    = 1'b0;
      timeout_err_d = 1'b0;
      last_byte_d   = last_byte_q;
      cnt_d         = cnt_q;
      busy_d0_d     = tx_busy;
      busy_d1_d     = busy_d0_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_id_d = pick_gnt;
               arb_busy_d = 1'b1;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            if (req_valid[grant_id_q]) begin
               tx_data_d   = req_byte[grant_id_q];
               last_byte_d = req_last[grant_id_q];
               state_d     = PULSE;
            end
         end
         PULSE: begin
            cnt_d   = '0;
            state_d = WAIT_START;
         end
         WAIT_START: begin
            if (busy_d0_q) begin
               state_d = WAIT_DONE;
            end else begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_d == START_TIMEOUT) begin
                  timeout_err_d = 1'b1;
                  state_d       = PULSE;
               end
            end
         end
         WAIT_DONE: begin
            // Falling edge of the synchronised busy marks the byte as fully shifted out.
            if (!busy_d0_q && busy_d1_q) begin
               cnt_d   = BYTE_GAP;
               state_d = GAP;
            end
         end
         GAP: begin
            if (cnt_q == 16'd0) begin
               if (!last_byte_q) begin
                  state_d = LOAD;
               end else begin
                  pkt_done_d   = 1'b1;
                  last_grant_d = grant_id_q;
                  arb_busy_d   = 1'b0;
                  state_d      = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      tx_pluse_d = (state_d == PULSE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         grant_id_q    <= '0;
         last_grant_q  <= GNT_W'(NUM_REQ - 1);
         tx_data_q     <= '0;
         tx_pluse_q    <= 1'b0;
         arb_busy_q    <= 1'b0;
         pkt_done_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         last_byte_q   <= 1'b0;
         cnt_q         <= '0;
         busy_d0_q     <= 1'b0;
         busy_d1_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         last_grant_q  <= last_grant_d;
         tx_data_q     <= tx_data_d;
         tx_pluse_q    <= tx_pluse_d;
         arb_busy_q    <= arb_busy_d;
         pkt_done_q    <= pkt_done_d;
         timeout_err_q <= timeout_err_d;
         last_byte_q   <= last_byte_d;
         cnt_q         <= cnt_d;
         busy_d0_q     <= busy_d0_d;
         busy_d1_q     <= busy_d1_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_pluse    = tx_pluse_q;
   assign grant_id    = grant_id_q;
   assign arb_busy    = arb_busy_q;
   assign pkt_done    = pkt_done_q;
   assign timeout_err = timeout_err_q;

endmodule
